// File: rtl/keypad_pkg.sv
// Shared constants, row-state type and key numbering for the 4x3 keypad scanner.
// Key numbers are 1-based: k = row*NUM_COLS + col + 1.
package keypad_pkg;

   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 3;
   localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

   typedef enum logic [1:0] {
      ROW0 = 2'd0,
      ROW1 = 2'd1,
      ROW2 = 2'd2,
      ROW3 = 2'd3
   } row_state_e;

   function automatic int key_index(input int row, input int col);
      return row * NUM_COLS + col + 1;
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// One key's stable level S and disagreement counter C; flips S after DEBOUNCE_SCANS
// consecutive disagreeing samples. press_pulse is registered with S on a 0->1 flip.
module key_debouncer #(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic sample_en,
   input  logic sample,
   output logic stable,
   output logic press_pulse
);

   logic       stable_q, stable_d;
   logic [3:0] cnt_q, cnt_d;
   logic       pulse_q, pulse_d;

   always_comb begin
      stable_d = stable_q;
      cnt_d    = cnt_q;
      pulse_d  = 1'b0;
      if (sample_en) begin
         if (sample == stable_q) begin
            cnt_d = 4'd0;
         end else if (cnt_q + 4'd1 == 4'(DEBOUNCE_SCANS)) begin
            stable_d = sample;
            cnt_d    = 4'd0;
            pulse_d  = sample;
         end else begin
            cnt_d = cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         stable_q <= 1'b0;
         cnt_q    <= 4'd0;
         pulse_q  <= 1'b0;
      end else begin
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         pulse_q  <= pulse_d;
      end
   end

   assign stable      = stable_q;
   assign press_pulse = pulse_q;

endmodule

// File: rtl/keypad_event_scanner.sv
// Scans a 4x3 key matrix row by row, debounces each key and emits one-cycle press pulses.
// Columns are sampled once per row dwell, at its last cycle; no backpressure on outputs.
module keypad_event_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 20000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic                CLK,
   input  logic                RST,
   output logic [NUM_ROWS-1:0] key_row,
   input  logic [NUM_COLS-1:0] key_col,
   output logic                event_1,
   output logic                event_2,
   output logic                event_3,
   output logic                event_4,
   output logic                event_5,
   output logic                event_6,
   output logic                event_7,
   output logic                event_8,
   output logic                event_9,
   output logic                event_10,
   output logic                event_11,
   output logic                event_12,
   output logic [NUM_KEYS-1:0] key_pressed,
   output logic                any_key
);

   localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic [NUM_COLS-1:0] col_s1_q, col_s2_q, col_pressed;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic                dwell_end;
   row_state_e          state_q, state_d;
   logic [NUM_KEYS-1:0] stable_w, pulse_w;

   // Sync flops reset to "released" so a held key is re-debounced from scratch.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         col_s1_q <= '1;
         col_s2_q <= '1;
         dwell_q  <= '0;
         state_q  <= ROW0;
      end else begin
         col_s1_q <= key_col;
         col_s2_q <= col_s1_q;
         dwell_q  <= dwell_d;
         state_q  <= state_d;
      end
   end

   assign col_pressed = ~col_s2_q;
   assign dwell_end   = (dwell_q == DW'(SCAN_DIV - 1));
   assign dwell_d     = dwell_end ? '0 : dwell_q + 1'b1;

   always_comb begin
      state_d = state_q;
      key_row = 4'b1110;
      case (state_q)
         ROW0: begin key_row = 4'b1110; if (dwell_end) state_d = ROW1; end
         ROW1: begin key_row = 4'b1101; if (dwell_end) state_d = ROW2; end
         ROW2: begin key_row = 4'b1011; if (dwell_end) state_d = ROW3; end
         ROW3: begin key_row = 4'b0111; if (dwell_end) state_d = ROW0; end
         default: begin key_row = 4'b1110; state_d = ROW0; end
      endcase
   end

   for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
      for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
         localparam int K = key_index(r, c) - 1;
         key_debouncer #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
         ) u_deb (
            .CLK        (CLK),
            .RST        (RST),
            .sample_en  (dwell_end & ~key_row[r]),
            .sample     (col_pressed[c]),
            .stable     (stable_w[K]),
            .press_pulse(pulse_w[K])
         );
      end
   end

   assign key_pressed = stable_w;
   assign any_key     = |stable_w;
   assign event_1     = pulse_w[0];
   assign event_2     = pulse_w[1];
   assign event_3     = pulse_w[2];
   assign event_4     = pulse_w[3];
   assign event_5     = pulse_w[4];
   assign event_6     = pulse_w[5];
   assign event_7     = pulse_w[6];
   assign event_8     = pulse_w[7];
   assign event_9     = pulse_w[8];
   assign event_10    = pulse_w[9];
   assign event_11    = pulse_w[10];
   assign event_12    = pulse_w[11];

endmodule

// File: doc/keypad_event_scanner.md
# keypad_event_scanner

Upstream input stage for the event handler. Scans a 4-row × 3-column push-button matrix and debounces each of the 12 keys. Emits one-cycle press pulses on `event_1`..`event_12`, which feed the LED, RGB, segment and single-segment handlers directly. It also exports debounced key levels for handlers that need hold state.

## Interface
Parameters:
- `SCAN_DIV`, default 20000: CLK cycles each row is driven (row dwell).
- `DEBOUNCE_SCANS`, default 4: consecutive disagreeing samples required to flip a key's stable state (range 1..15).

Ports:
- `CLK` in 1: system clock; all state on rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `key_row` out 4: row drive, active-low, exactly one bit low at any time.
- `key_col` in 3: column sense, active-low (pulled up externally), asynchronous to CLK.
- `event_1`..`event_12` out 1 each: single-cycle press pulse for key k.
- `key_pressed` out 12: debounced level; bit k-1 = key k held.
- `any_key` out 1: OR of `key_pressed`.

## Operation
- **Key mapping:** key index k = row*3 + col + 1, with row 0..3 and col 0..2. So row 0 holds keys 1–3 and row 3 holds keys 10–12.
- **Synchroniser:** `key_col` passes through a 2-flop synchroniser. The sampled column value is inverted (pressed = 1).
- **Scan FSM:**
  - States ROW0→ROW1→ROW2→ROW3→ROW0, in one-hot or 2-bit encoding.
  - Each state drives its row low and lasts SCAN_DIV cycles, counted by a dwell counter 0..SCAN_DIV-1.
  - Columns are sampled only when dwell = SCAN_DIV-1, i.e. at the end of the dwell, after settling.
  - On that same edge the FSM advances to the next row.
- **Frame:** one frame is 4*SCAN_DIV cycles. Each key is sampled once per frame.
- **Per-key debounce:**
  - Each key has a stable bit S and a counter C.
  - Only the 3 keys of the current row update at a sample instant.
  - If the sample equals S: C←0.
  - Otherwise: C←C+1.
  - If C+1 = DEBOUNCE_SCANS: S←sample and C←0.
- **Event generation:**
  - S 0→1 makes `event_k`=1 for exactly the next cycle (registered on the same edge as S).
  - S 1→0 makes no event; only `key_pressed` clears.
- **Simultaneous presses:**
  - Keys in the same row may flip on the same edge; their events pulse together.
  - Keys in different rows flip on different sample instants.
  - Ghost keys from matrix aliasing are not suppressed; they are reported as pressed.
- **Reset:**
  - Assertion at any time clears FSM, dwell, S, C and events immediately.
  - A key held across reset release is re-detected as a fresh press after full debounce.

## Timing
- **Reset values:**
  - `key_row`=4'b1110 (ROW0).
  - `event_*`=0, `key_pressed`=12'h000, `any_key`=0.
  - Dwell=0; all C=0, all S=0.
- **Row timing:** the row changes every SCAN_DIV cycles. The first change is at cycle SCAN_DIV after reset release.
- **Press latency:**
  - Measured from a clean, stable press at the pin.
  - Minimum: 2 sync cycles + (DEBOUNCE_SCANS-1) frames + up to 1 frame of scan alignment.
  - `event_k` rises 1 cycle after the qualifying sample edge.
  - Maximum: 2 + DEBOUNCE_SCANS*4*SCAN_DIV + 1 cycles.
- **Release latency:** same bounds, observed on `key_pressed`.
- **Event spacing:** `event_k` is never asserted for two consecutive cycles. Minimum spacing between successive press events of the same key is 2*DEBOUNCE_SCANS frames.
- **`any_key`:** combinational OR of registered `key_pressed`; no extra latency.

## Structure
- **Package `keypad_pkg`:**
  - Constants `NUM_ROWS`=4, `NUM_COLS`=3, `NUM_KEYS`=12.
  - Row-state typedef.
  - Function mapping (row, col) → key index.
- **Sub-module `key_debouncer`:**
  - Ports: CLK, RST, sample_en, sample, stable, press_pulse.
  - Holds S and C.
  - 12 instances, with sample_en = (dwell end) AND (FSM row = key's row).
- **Top level:** synchroniser, dwell counter, row FSM, column-to-key fan-out, and output assigns.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3, giving a frame of 16 cycles.
- **Reset and scan:**
  - Stimulus: hold RST=0, then release with no keys pressed.
  - Required: `key_row`=1110, then 1101, 1011, 0111, 1110, changing every 4 cycles; all outputs 0.
- **Single press:**
  - Stimulus: hold key 5 (row1, col1) clean.
  - Required: `event_5` pulses exactly once, for 1 cycle, within 2+48+1 cycles. `key_pressed`=12'h010 and stays set. No other event.
- **Bounce:**
  - Stimulus: toggle key 5 every 10 cycles for 40 cycles, then hold.
  - Required: exactly one `event_5` pulse, occurring after the hold starts.
- **Release:**
  - Stimulus: release key 5.
  - Required: `key_pressed` returns to 0 within 51 cycles; no event pulse.
- **Same-row pair:**
  - Stimulus: press keys 1 and 3 on the same cycle.
  - Required: `event_1` and `event_3` pulse on the same cycle; `key_pressed`=12'h005.
- **Reset mid-debounce:**
  - Stimulus: press key 12 and assert RST after 2 of its samples, then release RST with key 12 still held.
  - Required: `event_12` absent until 3 fresh row-3 samples after reset, then one pulse.
